// File: rtl/spi_cmd_controller_pkg.sv
// rtl/spi_cmd_controller_pkg.sv - shared types, default sizes and helpers for the SPI command controller
package spi_cmd_controller_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_TIMEOUT = 255;

  localparam int OP_W   = 2;
  localparam int STAT_W = 2;
  localparam int CNT_W  = 8;

  typedef enum logic [OP_W-1:0] {
    OP_NOP    = 2'b00,
    OP_WRITE  = 2'b01,
    OP_READ   = 2'b10,
    OP_STATUS = 2'b11
  } opcode_e;

  typedef enum logic [STAT_W-1:0] {
    STAT_OK        = 2'b00,
    STAT_TIMEOUT   = 2'b01,
    STAT_BAD_FRAME = 2'b10,
    STAT_OVERRUN   = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    CTRL_IDLE   = 2'b00,
    CTRL_DECODE = 2'b01,
    CTRL_REQ    = 2'b10,
    CTRL_RESP   = 2'b11
  } ctrl_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/spi_cmd_controller_if.sv
// rtl/spi_cmd_controller_if.sv - register-bank req/gnt access bus
interface spi_cmd_controller_if
  import spi_cmd_controller_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              reg_req;
  logic              reg_we;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_gnt;
  logic [DATA_W-1:0] reg_rdata;

  modport master (
    output reg_req, reg_we, reg_addr, reg_wdata,
    input  reg_gnt, reg_rdata
  );

  modport slave (
    input  reg_req, reg_we, reg_addr, reg_wdata,
    output reg_gnt, reg_rdata
  );
endinterface

// File: rtl/spi_cmd_controller_frame_decoder.sv
// rtl/spi_cmd_controller_frame_decoder.sv - combinational frame field split and parity check
// SPI_CMD_PARITY_EN: bit [DATA_W] is an even-parity bit over the whole frame.
module spi_cmd_controller_frame_decoder
  import spi_cmd_controller_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [WIDTH-1:0]  frame,
  output opcode_e           opcode,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              parity_ok
);

  assign opcode = opcode_e'(frame[WIDTH-1 -: OP_W]);
  assign addr   = frame[WIDTH-1-OP_W -: ADDR_W];
  assign data   = frame[DATA_W-1:0];

`ifdef SPI_CMD_PARITY_EN
  assign parity_ok = ~(^frame);
`else
  // Reserved bits carry no meaning without parity; fold them so they are visibly consumed.
  logic unused_frame_bits;
  assign unused_frame_bits = ^frame;
  assign parity_ok         = 1'b1;
`endif

endmodule

// File: rtl/spi_cmd_controller.sv
// rtl/spi_cmd_controller.sv - decodes SPI frames, runs one register access each, builds the MISO response
module spi_cmd_controller
  import spi_cmd_controller_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                  sys_clk,
  input  logic                  sys_reset,
  input  logic [WIDTH-1:0]      frame,
  input  logic                  frame_valid,
  spi_cmd_controller_if.master  reg_bus,
  output logic [WIDTH-1:0]      resp_word,
  output logic                  resp_load,
  output logic                  busy,
  output logic [CNT_W-1:0]      frame_cnt,
  output logic [CNT_W-1:0]      err_cnt
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  ctrl_state_e       state_q, state_d;
  logic [WIDTH-1:0]  frame_q, frame_d;
  logic              fv_prev_q, fv_prev_d;
  logic [TO_W-1:0]   wait_q, wait_d;
  status_e           status_q, status_d;
  logic [WIDTH-1:0]  resp_q, resp_d;
  logic              overrun_q, overrun_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  opcode_e           dec_op;
  logic [ADDR_W-1:0] dec_addr;
  logic [DATA_W-1:0] dec_data;
  logic              dec_parity_ok;

  spi_cmd_controller_frame_decoder #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_decoder (
    .frame     (frame_q),
    .opcode    (dec_op),
    .addr      (dec_addr),
    .data      (dec_data),
    .parity_ok (dec_parity_ok)
  );

  logic                fv_edge;
  logic [2*CNT_W-1:0]  stat_word;
  logic [DATA_W-1:0]   stat_data;
  logic                enter_resp;
  status_e             resp_status;
  logic [DATA_W-1:0]   resp_data;

  assign fv_edge   = frame_valid && !fv_prev_q;
  assign stat_word = {err_cnt_q, frame_cnt_q};

  always_comb begin
    stat_data = '0;
    for (int i = 0; i < DATA_W && i < 2 * CNT_W; i++) begin
      stat_data[i] = stat_word[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    fv_prev_d   = frame_valid;
    wait_d      = wait_q;
    status_d    = status_q;
    resp_d      = resp_q;
    overrun_d   = overrun_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    enter_resp  = 1'b0;
    resp_status = STAT_OK;
    resp_data   = '0;

    // Any new frame arriving while a transaction is in flight is dropped, even in RESP.
    if (fv_edge && state_q != CTRL_IDLE) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      CTRL_IDLE: begin
        if (fv_edge) begin
          frame_d     = frame;
          frame_cnt_d = frame_cnt_q + 1'b1;
          state_d     = CTRL_DECODE;
        end
      end
      CTRL_DECODE: begin
        wait_d = '0;
        if (!dec_parity_ok) begin
          enter_resp  = 1'b1;
          resp_status = STAT_BAD_FRAME;
          resp_data   = dec_data;
        end else begin
          case (dec_op)
            OP_WRITE, OP_READ: state_d = CTRL_REQ;
            OP_STATUS: begin
              enter_resp = 1'b1;
              resp_data  = stat_data;
            end
            default: enter_resp = 1'b1;
          endcase
        end
      end
      CTRL_REQ: begin
        if (reg_bus.reg_gnt) begin
          enter_resp = 1'b1;
          resp_data  = (dec_op == OP_WRITE) ? dec_data : reg_bus.reg_rdata;
        end else if (wait_q == TO_LAST) begin
          enter_resp  = 1'b1;
          resp_status = STAT_TIMEOUT;
          resp_data   = (dec_op == OP_WRITE) ? dec_data : '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      CTRL_RESP: begin
        if (status_q != STAT_OK) begin
          err_cnt_d = sat_inc(err_cnt_q);
        end
        state_d = CTRL_IDLE;
      end
      default: state_d = CTRL_IDLE;
    endcase

    // The sticky overrun is consumed by the response being formed, so it is counted once.
    if (enter_resp) begin
      status_d = (resp_status == STAT_OK && overrun_d) ? STAT_OVERRUN : resp_status;
      overrun_d = 1'b0;
      resp_d = '0;
      resp_d[WIDTH-1 -: STAT_W]        = status_d;
      resp_d[WIDTH-1-STAT_W -: ADDR_W] = dec_addr;
      resp_d[DATA_W-1:0]               = resp_data;
      state_d = CTRL_RESP;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state_q     <= CTRL_IDLE;
      frame_q     <= '0;
      fv_prev_q   <= 1'b0;
      wait_q      <= '0;
      status_q    <= STAT_OK;
      resp_q      <= '0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      fv_prev_q   <= fv_prev_d;
      wait_q      <= wait_d;
      status_q    <= status_d;
      resp_q      <= resp_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign reg_bus.reg_req   = (state_q == CTRL_REQ);
  assign reg_bus.reg_we    = (state_q == CTRL_REQ) && (dec_op == OP_WRITE);
  assign reg_bus.reg_addr  = dec_addr;
  assign reg_bus.reg_wdata = dec_data;

  assign resp_word = resp_q;
  assign resp_load = (state_q == CTRL_RESP);
  assign busy      = (state_q != CTRL_IDLE);
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_spi_cmd_controller.sv
// tb/tb_spi_cmd_controller.sv - directed self-checking bench for spi_cmd_controller (honours SPI_CMD_PARITY_EN)
module tb_spi_cmd_controller;

  logic        sys_clk = 1'b0;
  logic        sys_reset;
  logic [31:0] frame;
  logic        frame_valid;
  logic [31:0] resp_word;
  logic        resp_load;
  logic        busy;
  logic [7:0]  frame_cnt;
  logic [7:0]  err_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  spi_cmd_controller_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  spi_cmd_controller #(
    .WIDTH   (32),
    .ADDR_W  (8),
    .DATA_W  (16),
    .TIMEOUT (255)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_reset   (sys_reset),
    .frame       (frame),
    .frame_valid (frame_valid),
    .reg_bus     (bus),
    .resp_word   (resp_word),
    .resp_load   (resp_load),
    .busy        (busy),
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [31:0] mk_frame(input logic [1:0] op, input logic [7:0] addr,
                                           input logic [15:0] data);
    logic [31:0] f;
    f = {op, addr, 6'b0, data};
`ifdef SPI_CMD_PARITY_EN
    f[16] = ^f;
`endif
    return f;
  endfunction

  // Raises frame_valid for one cycle; returns with the DUT in DECODE.
  task automatic send(input logic [31:0] f);
    frame       = f;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
  endtask

  int req_cycles;
  int cyc;
  logic seen_load;

  initial begin
    sys_reset   = 1'b1;
    frame       = '0;
    frame_valid = 1'b0;
    bus.reg_gnt   = 1'b0;
    bus.reg_rdata = '0;
    tick();
    tick();
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_req", {31'b0, bus.reg_req}, 32'd0);
    check_eq("rst_load", {31'b0, resp_load}, 32'd0);
    check_eq("rst_resp", resp_word, 32'h0);
    check_eq("rst_cnts", {16'b0, err_cnt, frame_cnt}, 32'h0);
    sys_reset = 1'b0;
    tick();

    // 1: WRITE 0x12 <- 0xABCD, grant on the fourth request cycle
    send(mk_frame(2'b01, 8'h12, 16'hABCD));
    check_eq("t1_decode_busy", {31'b0, busy}, 32'd1);
    tick();
    check_eq("t1_req", {31'b0, bus.reg_req}, 32'd1);
    check_eq("t1_bus", {7'b0, bus.reg_we, bus.reg_addr, bus.reg_wdata}, 32'h0112ABCD);
    tick();
    tick();
    tick();
    check_eq("t1_req_held", {31'b0, bus.reg_req}, 32'd1);
    bus.reg_gnt = 1'b1;
    tick();
    bus.reg_gnt = 1'b0;
    check_eq("t1_load", {31'b0, resp_load}, 32'd1);
    check_eq("t1_resp", resp_word, 32'h0480ABCD);
    tick();
    check_eq("t1_idle", {30'b0, busy, resp_load}, 32'd0);
    check_eq("t1_cnts", {16'b0, err_cnt, frame_cnt}, 32'h0001);

    // 2: READ 0x05, grant with data on the first request cycle
    send(mk_frame(2'b10, 8'h05, 16'h0000));
    tick();
    check_eq("t2_bus", {7'b0, bus.reg_we, bus.reg_addr, bus.reg_wdata}, 32'h00050000);
    bus.reg_gnt   = 1'b1;
    bus.reg_rdata = 16'h1234;
    tick();
    bus.reg_gnt   = 1'b0;
    bus.reg_rdata = '0;
    check_eq("t2_load", {31'b0, resp_load}, 32'd1);
    check_eq("t2_resp", resp_word, 32'h01401234);
    tick();
    check_eq("t2_hold", resp_word, 32'h01401234);

    // 3: READ 0x07 never granted -> TIMEOUT after exactly 255 request cycles
    send(mk_frame(2'b10, 8'h07, 16'h0000));
    tick();
    req_cycles = 0;
    seen_load  = 1'b0;
    for (cyc = 0; cyc < 400; cyc++) begin
      if (resp_load) begin
        seen_load = 1'b1;
        break;
      end
      if (bus.reg_req) req_cycles++;
      tick();
    end
    check_eq("t3_reached_resp", {31'b0, seen_load}, 32'd1);
    check_eq("t3_req_cycles", req_cycles, 32'd255);
    check_eq("t3_resp", resp_word, 32'h41C00000);
    tick();
    check_eq("t3_cnts", {16'b0, err_cnt, frame_cnt}, 32'h0103);

    // 4: second edge during REQ is dropped and the first reports OVERRUN
    sys_reset = 1'b1;
    tick();
    sys_reset = 1'b0;
    tick();
    send(mk_frame(2'b01, 8'h20, 16'h5555));
    tick();
    frame       = mk_frame(2'b10, 8'h44, 16'h0000);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    check_eq("t4_cnt_not_bumped", {24'b0, frame_cnt}, 32'd1);
    bus.reg_gnt = 1'b1;
    tick();
    bus.reg_gnt = 1'b0;
    check_eq("t4_load", {31'b0, resp_load}, 32'd1);
    check_eq("t4_resp", resp_word, 32'hC8005555);
    tick();
    check_eq("t4_cnts", {16'b0, err_cnt, frame_cnt}, 32'h0101);
    tick();
    check_eq("t4_no_replay", {31'b0, busy}, 32'd0);

    // NOP right after: overrun is cleared, response at N+2
    send(mk_frame(2'b00, 8'h00, 16'h0000));
    tick();
    check_eq("nop_load", {31'b0, resp_load}, 32'd1);
    check_eq("nop_resp", resp_word, 32'h00000000);
    tick();
    check_eq("nop_cnts", {16'b0, err_cnt, frame_cnt}, 32'h0102);

    // 5: reset during REQ
    send(mk_frame(2'b10, 8'h05, 16'h0000));
    tick();
    check_eq("t5_in_req", {31'b0, bus.reg_req}, 32'd1);
    sys_reset = 1'b1;
    tick();
    check_eq("t5_req", {31'b0, bus.reg_req}, 32'd0);
    check_eq("t5_busy", {31'b0, busy}, 32'd0);
    check_eq("t5_cnts", {16'b0, err_cnt, frame_cnt}, 32'h0000);
    sys_reset = 1'b0;
    seen_load = resp_load;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen_load = seen_load | resp_load | busy;
    end
    check_eq("t5_quiet", {31'b0, seen_load}, 32'd0);

    // 6: WRITE 0x33 <- 0x0F0F with bit16 clear (odd parity), then STATUS
    send(32'h4CC00F0F);
    tick();
`ifdef SPI_CMD_PARITY_EN
    check_eq("t6_no_req", {31'b0, bus.reg_req}, 32'd0);
    check_eq("t6_load", {31'b0, resp_load}, 32'd1);
    check_eq("t6_resp", resp_word, 32'h8CC00F0F);
    tick();
    check_eq("t6_cnts", {16'b0, err_cnt, frame_cnt}, 32'h0101);
    send(mk_frame(2'b11, 8'h00, 16'h0000));
    tick();
    check_eq("t6_status_load", {31'b0, resp_load}, 32'd1);
    check_eq("t6_status_resp", resp_word, 32'h00000102);
`else
    check_eq("t6_req", {31'b0, bus.reg_req}, 32'd1);
    bus.reg_gnt = 1'b1;
    tick();
    bus.reg_gnt = 1'b0;
    check_eq("t6_resp", resp_word, 32'h0CC00F0F);
    tick();
    check_eq("t6_cnts", {16'b0, err_cnt, frame_cnt}, 32'h0001);
    send(mk_frame(2'b11, 8'h00, 16'h0000));
    tick();
    check_eq("t6_status_load", {31'b0, resp_load}, 32'd1);
    check_eq("t6_status_resp", resp_word, 32'h00000002);
`endif
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
